// File: rtl/bounce_pkg.sv
// Shared types for the bounce scheduler: per-object state record and sweep FSM states.
// Coordinate and speed widths are fixed here because obj_t is shared by every user.
package bounce_pkg;
    localparam int CORDW = 12;
    localparam int SPDW  = 4;

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
        logic             dx;
        logic             dy;
        logic [SPDW-1:0]  spd;
    } obj_t;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, STORE, DONE} state_t;
endpackage

// File: rtl/bounce_axis.sv
// One-axis bounce step: new position/direction from current ones, reflecting at 0 and limit.
// Purely combinational (0 cycles); no flow control.
module bounce_axis
    import bounce_pkg::*;
#(
    parameter int Q_SIZE = 200
) (
    input  logic [CORDW-1:0] pos,
    input  logic             dir,
    input  logic [SPDW-1:0]  spd,
    input  logic [CORDW:0]   limit,
    output logic [CORDW-1:0] pos_next,
    output logic             dir_next
);
    localparam int EW = CORDW + 1;

    logic [CORDW:0] pos_w;
    logic [CORDW:0] spd_w;
    logic [CORDW:0] far_edge;

    // One extra bit so out-of-range positions plus square size never wrap.
    always_comb begin
        pos_w    = {1'b0, pos};
        spd_w    = EW'(spd);
        far_edge = pos_w + EW'(Q_SIZE) + spd_w;
        pos_next = pos;
        dir_next = dir;
        if (!dir) begin
            if (far_edge >= limit - EW'(1)) begin
                pos_next = CORDW'(limit - EW'(Q_SIZE) - EW'(1));
                dir_next = 1'b1;
            end else begin
                pos_next = pos + CORDW'(spd);
            end
        end else begin
            if (pos_w < spd_w) begin
                pos_next = '0;
                dir_next = 1'b0;
            end else begin
                pos_next = pos - CORDW'(spd);
            end
        end
    end
endmodule

// File: rtl/bounce_scheduler.sv
// Sweeps one shared bounce datapath over OBJ_N objects per animated frame, 3 cycles/object + 1 done cycle.
// Config writes are refused (cfg_ready low) for the whole sweep; reads are always served with 1-cycle latency.
module bounce_scheduler
    import bounce_pkg::*;
#(
    parameter int OBJ_N   = 4,
    parameter int H_RES   = 1280,
    parameter int V_RES   = 720,
    parameter int Q_SIZE  = 200,
    parameter int FRAME_N = 1,
    localparam int IDW    = (OBJ_N > 1) ? $clog2(OBJ_N) : 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             frame,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [IDW-1:0]   cfg_id,
    input  logic [CORDW-1:0] cfg_x,
    input  logic [CORDW-1:0] cfg_y,
    input  logic             cfg_dx,
    input  logic             cfg_dy,
    input  logic [SPDW-1:0]  cfg_spd,
    input  logic [IDW-1:0]   rd_id,
    output logic [CORDW-1:0] rd_x,
    output logic [CORDW-1:0] rd_y,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    localparam int EW  = CORDW + 1;
    localparam int FCW = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;
    localparam logic [IDW-1:0] LAST_ID  = IDW'(OBJ_N - 1);
    localparam logic [FCW-1:0] LAST_FRM = FCW'(FRAME_N - 1);
    localparam logic [CORDW:0] H_LIM    = EW'(H_RES);
    localparam logic [CORDW:0] V_LIM    = EW'(V_RES);

    state_t           state;
    state_t           state_nxt;
    obj_t             obj [OBJ_N];
    obj_t             work;
    logic [IDW-1:0]   idx;
    logic [FCW-1:0]   frm_cnt;
    logic [CORDW-1:0] x_nxt;
    logic [CORDW-1:0] y_nxt;
    logic             dx_nxt;
    logic             dy_nxt;

    bounce_axis #(.Q_SIZE(Q_SIZE)) u_axis_x (
        .pos(work.x), .dir(work.dx), .spd(work.spd), .limit(H_LIM),
        .pos_next(x_nxt), .dir_next(dx_nxt)
    );

    bounce_axis #(.Q_SIZE(Q_SIZE)) u_axis_y (
        .pos(work.y), .dir(work.dy), .spd(work.spd), .limit(V_LIM),
        .pos_next(y_nxt), .dir_next(dy_nxt)
    );

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cfg_ready = !busy;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame && frm_cnt == '0) state_nxt = LOAD;
            LOAD:    state_nxt = CALC;
            CALC:    state_nxt = STORE;
            STORE:   state_nxt = (idx == LAST_ID) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state   <= IDLE;
            idx     <= '0;
            work    <= '0;
            frm_cnt <= '0;
            overrun <= 1'b0;
            rd_x    <= '0;
            rd_y    <= '0;
            for (int i = 0; i < OBJ_N; i++) obj[i] <= '0;
        end else begin
            state <= state_nxt;
            rd_x  <= obj[rd_id].x;
            rd_y  <= obj[rd_id].y;
            if (frame) begin
                frm_cnt <= (frm_cnt == LAST_FRM) ? '0 : frm_cnt + 1'b1;
                if (busy) overrun <= 1'b1;
            end
            // Config writes land only in IDLE, so they never collide with STORE.
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    if (cfg_we) begin
                        obj[cfg_id] <= '{x: cfg_x, y: cfg_y, dx: cfg_dx, dy: cfg_dy, spd: cfg_spd};
                    end
                end
                LOAD:  work <= obj[idx];
                CALC:  work <= '{x: x_nxt, y: y_nxt, dx: dx_nxt, dy: dy_nxt, spd: work.spd};
                STORE: begin
                    obj[idx] <= work;
                    if (idx != LAST_ID) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
